// File: rtl/uart_pkg.sv
// Shared types and frame constants for the acknowledged UART receiver.
// Used by uart_rx_ack; the ack path is built only with UART_RX_ACK_EN defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    ACK_WAIT = 3'd4,
    ACK_SEND = 3'd5
  } rx_state_e;

  localparam logic [7:0] ACK_BYTE_DEF = 8'hCC;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Line level of bit idx of an 8N1 frame: start, data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] byte_v, input logic [3:0] idx);
    logic [9:0] fr;
    fr = {1'b1, byte_v, 1'b0};
    if (idx < 4'(FRAME_BITS)) begin
      frame_bit = fr[idx];
    end else begin
      frame_bit = 1'b1;
    end
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running divider producing a one-clk sample-tick enable every DIV clocks.
module uart_rx_tick_gen #(
  parameter int DIV = 163
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // wrap counter and flag the wrap cycle
  always_comb begin
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_ack.sv
// 8N1 UART receiver that answers each good frame with ACK_BYTE on ack_out.
// The acknowledge path is compiled in only when UART_RX_ACK_EN is defined.
module uart_rx_ack
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ       = 50000000,
  parameter int          BAUD           = 19200,
  parameter int          OVERSAMPLE     = 16,
  parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEF,
  parameter int          ACK_DELAY_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       ack_out,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rx_busy,
  output logic [2:0] state_rx
);

  localparam int DIV   = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  // OVERSAMPLE is a power of two, so os_cnt wraps naturally
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int DLY_W = $clog2(ACK_DELAY_BITS * OVERSAMPLE + 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
`ifdef UART_RX_ACK_EN
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ACK_DELAY_BITS * OVERSAMPLE - 1);
`endif

  logic            tick_s, rx_s, at_mid_s, at_last_s;
  logic            sync1_q, sync2_q;
  rx_state_e       state_q, state_d;
  logic [OS_W-1:0] os_q, os_d;
  logic [3:0]      bit_q, bit_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [7:0]      shreg_q, shreg_d, data_q, data_d;
  logic            dv_q, dv_d, fe_q, fe_d, ack_q, ack_d, busy_q, busy_d, armed_q, armed_d;

  uart_rx_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign rx_s      = sync2_q;
  assign at_mid_s  = tick_s && (os_q == OS_MID);
  assign at_last_s = tick_s && (os_q == OS_LAST);

  // next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    os_d    = tick_s ? os_q + OS_W'(1) : os_q;
    bit_d   = bit_q;
    dly_d   = dly_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    armed_d = armed_q;
    case (state_q)
      IDLE: begin
        armed_d = armed_q | rx_s;
        if (tick_s && armed_q && !rx_s) begin
          os_d    = '0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (at_mid_s) begin
          if (!rx_s) begin
            os_d    = '0;
            bit_d   = 4'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (at_last_s) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (at_last_s) begin
          if (rx_s) begin
            data_d  = shreg_q;
            dv_d    = 1'b1;
`ifdef UART_RX_ACK_EN
            dly_d   = '0;
            state_d = ACK_WAIT;
`else
            state_d = IDLE;
`endif
          end else begin
            fe_d    = 1'b1;
            armed_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
`ifdef UART_RX_ACK_EN
      ACK_WAIT: begin
        if (tick_s && (dly_q == DLY_LAST)) begin
          os_d    = '0;
          bit_d   = 4'd0;
          state_d = ACK_SEND;
        end else if (tick_s) begin
          dly_d   = dly_q + DLY_W'(1);
        end else begin
          state_d = ACK_WAIT;
        end
      end
      ACK_SEND: begin
        if (at_last_s && (bit_q == 4'(FRAME_BITS - 1))) begin
          armed_d = 1'b0;
          state_d = IDLE;
        end else if (at_last_s) begin
          bit_d   = bit_q + 4'd1;
        end else begin
          state_d = ACK_SEND;
        end
      end
`endif
      default: begin
        if (tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
    endcase
    // ACK_SEND is unreachable without the ack path, so ack_d stays high there
    ack_d  = (state_d == ACK_SEND) ? frame_bit(ACK_BYTE, bit_d) : 1'b1;
    busy_d = (state_d != IDLE);
  end

  // synchroniser, FSM and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= 4'd0;
      dly_q   <= '0;
      shreg_q <= 8'd0;
      data_q  <= 8'd0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      ack_q   <= 1'b1;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      dly_q   <= dly_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign ack_out    = ack_q;
  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign rx_busy    = busy_q;
  assign state_rx   = state_q;

endmodule

// File: tb/tb_uart_rx_ack.sv
// Directed bench for uart_rx_ack at a shortened bit time (4 clk per tick, 64 clk per bit).
// Ack expectations follow UART_RX_ACK_EN; without it ack_out must stay high.
module tb_uart_rx_ack;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       ack_out;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       rx_busy;
  logic [2:0] state_rx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int ack_low_cnt = 0;
  int st45_cnt = 0;
  int dv_cyc = 0;

  uart_rx_ack #(
    .CLK_FREQ       (1228800),
    .BAUD           (19200),
    .OVERSAMPLE     (16),
    .ACK_BYTE       (8'hCC),
    .ACK_DELAY_BITS (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .ack_out    (ack_out),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy),
    .state_rx   (state_rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (data_valid === 1'b1) begin
        dv_cnt++;
        dv_cyc = cyc;
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (data_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
      if (ack_out !== 1'b1) ack_low_cnt++;
      if (state_rx == 3'd4 || state_rx == 3'd5) st45_cnt++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_in = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_in = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic check_ack(input string tag);
`ifdef UART_RX_ACK_EN
    logic [9:0] seen;
    logic [9:0] exp_ack;
    logic [7:0] ack_byte;
    bit got;
    int t0;
    exp_ack = 10'b11_1001_1000;
    got = 1'b0;
    t0 = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ack_out === 1'b0) begin
        got = 1'b1;
        t0 = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s ack_start: got no start bit, required one within 400 clk", tag);
    end else begin
      checks++;
      if (t0 - dv_cyc < 60 || t0 - dv_cyc > 68) begin
        errors++;
        $display("FAIL %s ack_delay: got %0d clk, required 60..68", tag, t0 - dv_cyc);
      end
      repeat (BIT_CLKS / 2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        seen[k] = ack_out;
        if (k < 9) repeat (BIT_CLKS) @(negedge clk);
      end
      checks++;
      if (seen !== exp_ack) begin
        errors++;
        $display("FAIL %s ack_bits: got %b, required %b", tag, seen, exp_ack);
      end
      ack_byte = seen[8:1];
      checks++;
      if (ack_byte !== 8'd204) begin
        errors++;
        $display("FAIL %s ack_byte: got %0d, required 204", tag, ack_byte);
      end
      repeat (BIT_CLKS) @(negedge clk);
      checks++;
      if (ack_out !== 1'b1 || state_rx !== 3'd0) begin
        errors++;
        $display("FAIL %s ack_idle: got ack=%b state=%0d, required ack=1 state=0", tag, ack_out, state_rx);
      end
    end
`else
    int low0;
    low0 = ack_low_cnt;
    repeat (800) @(negedge clk);
    checks++;
    if (ack_low_cnt !== low0) begin
      errors++;
      $display("FAIL %s ack_tied: got %0d low clk, required 0", tag, ack_low_cnt - low0);
    end
    checks++;
    if (st45_cnt !== 0) begin
      errors++;
      $display("FAIL %s state_45: got %0d clk in state 4/5, required 0", tag, st45_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rx_in = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack_out, data_out, data_valid, frame_err, rx_busy, state_rx} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset_vals: got ack=%b data=%h dv=%b fe=%b busy=%b st=%0d, required 1 00 0 0 0 0",
               ack_out, data_out, data_valid, frame_err, rx_busy, state_rx);
    end
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (state_rx !== 3'd0 || ack_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle: got state=%0d ack=%b, required 0 1", state_rx, ack_out);
    end
  endtask

  task automatic test_frame_a5();
    int dv0;
    dv0 = dv_cnt;
    send_frame(8'hA5, 1'b1);
    checks++;
    if (dv_cnt !== dv0 + 1) begin
      errors++;
      $display("FAIL a5_valid: got %0d pulses, required 1", dv_cnt - dv0);
    end
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL a5_data: got %h, required a5", data_out);
    end
    checks++;
    if (fe_cnt !== 0) begin
      errors++;
      $display("FAIL a5_ferr: got %0d, required 0", fe_cnt);
    end
    check_ack("a5");
  endtask

  task automatic test_glitch();
    int dv0, fe0, al0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    al0 = ack_low_cnt;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy: got %b, required 1", rx_busy);
    end
    repeat (4) @(negedge clk);
    rx_in = 1'b1;
    repeat (200) @(negedge clk);
    checks++;
    if (dv_cnt !== dv0 || fe_cnt !== fe0) begin
      errors++;
      $display("FAIL glitch_pulses: got dv=%0d fe=%0d, required 0 0", dv_cnt - dv0, fe_cnt - fe0);
    end
    checks++;
    if (ack_low_cnt !== al0 || state_rx !== 3'd0) begin
      errors++;
      $display("FAIL glitch_idle: got ack_low=%0d state=%0d, required 0 0", ack_low_cnt - al0, state_rx);
    end
  endtask

  task automatic test_frame_err();
    int dv0, fe0, al0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    al0 = ack_low_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++;
    if (fe_cnt !== fe0 + 1 || dv_cnt !== dv0) begin
      errors++;
      $display("FAIL ferr_pulse: got fe=%0d dv=%0d, required 1 0", fe_cnt - fe0, dv_cnt - dv0);
    end
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL ferr_data: got %h, required a5", data_out);
    end
    checks++;
    if (ack_low_cnt !== al0 || state_rx !== 3'd0) begin
      errors++;
      $display("FAIL ferr_noack: got ack_low=%0d state=%0d, required 0 0", ack_low_cnt - al0, state_rx);
    end
    dv0 = dv_cnt;
    send_frame(8'h11, 1'b1);
    checks++;
    if (dv_cnt !== dv0 + 1 || data_out !== 8'h11) begin
      errors++;
      $display("FAIL after_ferr: got dv=%0d data=%h, required 1 11", dv_cnt - dv0, data_out);
    end
    check_ack("x11");
  endtask

  task automatic test_reset_mid();
    int dv0;
    dv0 = dv_cnt;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx_in = 1'b1;
    repeat (4 * BIT_CLKS) @(negedge clk);
    checks++;
    if (state_rx !== 3'd2) begin
      errors++;
      $display("FAIL mid_state: got %0d, required 2", state_rx);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state_rx !== 3'd0 || rx_busy !== 1'b0 || data_out !== 8'h00 || ack_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got st=%0d busy=%b data=%h ack=%b, required 0 0 00 1",
               state_rx, rx_busy, data_out, ack_out);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++;
    if (dv_cnt !== dv0 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL mid_partial: got dv=%0d data=%h, required 0 00", dv_cnt - dv0, data_out);
    end
    send_frame(8'h42, 1'b1);
    checks++;
    if (dv_cnt !== dv0 + 1 || data_out !== 8'h42) begin
      errors++;
      $display("FAIL mid_x42: got dv=%0d data=%h, required 1 42", dv_cnt - dv0, data_out);
    end
    check_ack("x42");
  endtask

  task automatic test_back_to_back();
    int dv0;
    for (int n = 0; n < 2; n++) begin
      dv0 = dv_cnt;
      send_frame(8'h7E, 1'b1);
      checks++;
      if (dv_cnt !== dv0 + 1 || data_out !== 8'h7E) begin
        errors++;
        $display("FAIL b2b_x7e_%0d: got dv=%0d data=%h, required 1 7e", n, dv_cnt - dv0, data_out);
      end
      check_ack("x7e");
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL dv_fe_overlap: got %0d clk, required 0", both_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
